snake_game_ctrl: RTL and testbench

Game sequencer for the snake datapath. It runs the game state machine and paces moves with a step-rate divider. It drives the datapath's `start`, `step` and `grow` strobes, checks the new head position for wall, self and food hits, and requests new food from the food generator. It sits between the player start button, `snake_calculate`, the food generator and the score/display logic.

---
 rtl/snake_game_ctrl.sv | 140 ++++++++++++++
 tb/tb_snake_game_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: paces moves with a step divider, checks the new head for
// wall/self/food hits after each move, and tracks score, food requests and win/over.
//
// state | meaning
// IDLE  | waiting for the first start edge
// INIT  | one-cycle datapath init, clears game bookkeeping, requests first food
// RUN   | counting divider cycles until the next move
// CHECK | evaluating the freshly moved head
// OVER  | game ended (win holds its value), waiting for a restart edge
module snake_game_ctrl #(
    parameter int SIZE_X   = 10,
    parameter int SIZE_Y   = 10,
    parameter int STEP_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic [7:0]  head_x,
    input  logic [7:0]  head_y,
    input  logic        self_hit,
    input  logic [15:0] lengh,
    input  logic [7:0]  food_x,
    input  logic [7:0]  food_y,
    input  logic        food_ack,
    output logic        start,
    output logic        step,
    output logic        grow,
    output logic        food_req,
    output logic        game_over,
    output logic        win,
    output logic [15:0] score
);

    localparam int              DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [15:0]     LIM_X    = 16'(SIZE_X);
    localparam logic [15:0]     LIM_Y    = 16'(SIZE_Y);
    localparam logic [15:0]     CELLS    = 16'(SIZE_X * SIZE_Y);

    typedef enum logic [2:0] {IDLE, INIT, RUN, CHECK, OVER} state_t;

    state_t           state, state_nxt;
    logic             btn_q;
    logic             grow_pend;
    logic [DIV_W-1:0] divider;
    logic             start_edge, div_tc, wall_hit, field_full, food_hit;
    logic             eat, win_hit;

    assign start_edge = btn_start & ~btn_q;
    assign div_tc     = (divider == DIV_LAST);
    // Coordinates are unsigned, so a move off the low edge wraps to 255 and lands here too.
    assign wall_hit   = ({8'd0, head_x} >= LIM_X) || ({8'd0, head_y} >= LIM_Y);
    assign field_full = (lengh >= CELLS);
    assign food_hit   = (head_x == food_x) && (head_y == food_y);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        step      = 1'b0;
        grow      = 1'b0;
        game_over = 1'b0;
        eat       = 1'b0;
        win_hit   = 1'b0;
        case (state)
            IDLE: if (start_edge) state_nxt = INIT;
            INIT: begin
                start     = 1'b1;
                state_nxt = RUN;
            end
            RUN: if (div_tc) begin
                step      = 1'b1;
                grow      = grow_pend;
                state_nxt = CHECK;
            end
            CHECK: begin
                state_nxt = RUN;
                if (wall_hit || self_hit) begin
                    state_nxt = OVER;
                end else if (field_full) begin
                    win_hit   = 1'b1;
                    state_nxt = OVER;
                end else if (food_hit && !food_req) begin
                    // Food coordinates are stale while a request is outstanding.
                    eat = 1'b1;
                end
            end
            OVER: begin
                game_over = 1'b1;
                if (start_edge) state_nxt = INIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q     <= 1'b0;
            food_req  <= 1'b0;
            win       <= 1'b0;
            score     <= 16'd0;
            grow_pend <= 1'b0;
            divider   <= '0;
        end else begin
            btn_q <= btn_start;
            if (food_ack) food_req <= 1'b0;
            case (state)
                INIT: begin
                    score     <= 16'd0;
                    grow_pend <= 1'b0;
                    divider   <= '0;
                    win       <= 1'b0;
                    food_req  <= 1'b1;
                end
                RUN: begin
                    if (div_tc) begin
                        divider   <= '0;
                        grow_pend <= 1'b0;
                    end else begin
                        divider <= divider + 1'b1;
                    end
                end
                CHECK: begin
                    if (win_hit) win <= 1'b1;
                    if (eat) begin
                        score     <= score + 16'd1;
                        grow_pend <= 1'b1;
                        food_req  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: start timing, eat/grow, stale food,
// wall/self/win endings and mid-run reset, with a queue of expected step events.
module tb_snake_game_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_start = 1'b0;
    logic [7:0]  head_x = 8'd5;
    logic [7:0]  head_y = 8'd5;
    logic        self_hit = 1'b0;
    logic [15:0] lengh = 16'd3;
    logic [7:0]  food_x = 8'd0;
    logic [7:0]  food_y = 8'd0;
    logic        food_ack = 1'b0;
    logic        start, step, grow, food_req, game_over, win;
    logic [15:0] score;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    snake_game_ctrl #(.SIZE_X(10), .SIZE_Y(10), .STEP_DIV(4)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start),
        .head_x(head_x), .head_y(head_y), .self_hit(self_hit), .lengh(lengh),
        .food_x(food_x), .food_y(food_y), .food_ack(food_ack),
        .start(start), .step(step), .grow(grow), .food_req(food_req),
        .game_over(game_over), .win(win), .score(score)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (step) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_start();
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({start, step, grow, food_req, game_over, win} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000000", {start, step, grow, food_req, game_over, win});
        end
        checks++;
        if (score !== 16'd0) begin
            errors++;
            $display("FAIL reset_score got %0d want 0", score);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_start();
        int starts = 0;
        int start_k = -1;
        int e;
        btn_start = 1'b1;
        exp_q.push_back(5);
        exp_q.push_back(10);
        exp_q.push_back(15);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (start) begin
                starts++;
                if (start_k < 0) start_k = k;
            end
            if (k == 2) begin
                checks++;
                if (food_req !== 1'b1) begin
                    errors++;
                    $display("FAIL start_food_req got %b want 1", food_req);
                end
            end
            if (step) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL start_step_extra got step at %0d want none", k);
                end else begin
                    e = exp_q.pop_front();
                    if (k != e) begin
                        errors++;
                        $display("FAIL start_step_time got %0d want %0d", k, e);
                    end
                end
                checks++;
                if (grow !== 1'b0) begin
                    errors++;
                    $display("FAIL start_grow got %b want 0", grow);
                end
            end
            if (k == 10) btn_start = 1'b0;
        end
        checks++;
        if (starts != 1 || start_k != 1) begin
            errors++;
            $display("FAIL start_pulse got count %0d at %0d want count 1 at 1", starts, start_k);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL start_step_missing got %0d pending want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_eat();
        bit ok;
        int e;
        food_ack = 1'b1;
        tick();
        food_ack = 1'b0;
        checks++;
        if (food_req !== 1'b0) begin
            errors++;
            $display("FAIL eat_ack_clear got %b want 0", food_req);
        end
        wait_step(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL eat_wait_step got timeout want step");
        end
        head_x = 8'd3; head_y = 8'd2; food_x = 8'd3; food_y = 8'd2;
        tick();
        tick();
        checks++;
        if (score !== 16'd1 || food_req !== 1'b1) begin
            errors++;
            $display("FAIL eat_score got score %0d req %b want score 1 req 1", score, food_req);
        end
        head_x = 8'd5; head_y = 8'd5;
        exp_q.push_back(1);
        exp_q.push_back(0);
        for (int i = 0; i < 2; i++) begin
            wait_step(ok);
            checks++;
            e = exp_q.pop_front();
            if (!ok) begin
                errors++;
                $display("FAIL eat_grow_step%0d got timeout want step", i);
            end else if (int'(grow) != e) begin
                errors++;
                $display("FAIL eat_grow_step%0d got %b want %0d", i, grow, e);
            end
        end
    endtask

    task automatic test_stale_food();
        bit ok;
        head_x = 8'd3; head_y = 8'd2;
        for (int i = 0; i < 2; i++) begin
            wait_step(ok);
            checks++;
            if (!ok || grow !== 1'b0) begin
                errors++;
                $display("FAIL stale_grow%0d got ok %b grow %b want ok 1 grow 0", i, ok, grow);
            end
        end
        tick();
        tick();
        checks++;
        if (score !== 16'd1) begin
            errors++;
            $display("FAIL stale_score got %0d want 1", score);
        end
        head_x = 8'd5; head_y = 8'd5;
    endtask

    task automatic test_wall();
        bit ok;
        int steps = 0;
        wait_step(ok);
        head_x = 8'd255;
        tick();
        tick();
        checks++;
        if (!ok || game_over !== 1'b1 || win !== 1'b0) begin
            errors++;
            $display("FAIL wall_over got ok %b over %b win %b want 1 1 0", ok, game_over, win);
        end
        head_x = 8'd5;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (step) steps++;
        end
        checks++;
        if (steps != 0) begin
            errors++;
            $display("FAIL wall_no_step got %0d steps want 0", steps);
        end
        btn_start = 1'b1;
        tick();
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("FAIL wall_restart_start got %b want 1", start);
        end
        btn_start = 1'b0;
        tick();
        checks++;
        if (score !== 16'd0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL wall_restart_clear got score %0d over %b want 0 0", score, game_over);
        end
    endtask

    task automatic test_self_win();
        bit ok;
        wait_step(ok);
        self_hit = 1'b1;
        lengh = 16'd100;
        tick();
        tick();
        checks++;
        if (!ok || game_over !== 1'b1 || win !== 1'b0) begin
            errors++;
            $display("FAIL self_over got ok %b over %b win %b want 1 1 0", ok, game_over, win);
        end
        self_hit = 1'b0;
        do_start();
        wait_step(ok);
        tick();
        tick();
        checks++;
        if (!ok || game_over !== 1'b1 || win !== 1'b1) begin
            errors++;
            $display("FAIL win_over got ok %b over %b win %b want 1 1 1", ok, game_over, win);
        end
        repeat (3) tick();
        checks++;
        if (win !== 1'b1) begin
            errors++;
            $display("FAIL win_hold got %b want 1", win);
        end
        lengh = 16'd3;
        do_start();
        checks++;
        if (win !== 1'b0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL win_restart got win %b over %b want 0 0", win, game_over);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int active = 0;
        wait_step(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midrst_wait_step got timeout want step");
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({start, step, grow, food_req, game_over, win} !== 6'b0 || score !== 16'd0) begin
            errors++;
            $display("FAIL midrst_outputs got %b score %0d want 000000 score 0",
                     {start, step, grow, food_req, game_over, win}, score);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step || grow || start) active++;
        end
        checks++;
        if (active != 0) begin
            errors++;
            $display("FAIL midrst_idle got %0d active cycles want 0", active);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_eat();
        test_stale_food();
        test_wall();
        test_self_win();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
